// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and helpers for display blocks.
package seg7_pkg;

    // Active-high segment codes, bit order gfedcba.
    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Decimal nibble to active-high segments; non-decimal nibbles are blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] code;
        code = SEG_BLANK;
        for (int unsigned k = 0; k < 10; k++) begin
            if (nibble == 4'(k)) code = SEG_CODE[k];
        end
        return code;
    endfunction

    // 10**e in 64 bits, for elaboration-time limits.
    function automatic longint unsigned pow10(input int unsigned e);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned k = 0; k < e; k++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int IN_WIDTH   = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IN_WIDTH-1:0]       value,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + IN_WIDTH;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] shift_cnt;
    logic [SR_W-1:0]  shift_reg;   // {bcd, remaining binary}
    logic [BCD_W-1:0] bcd_adj;
    logic [SR_W-1:0]  shift_next;

    // Add-3 correction on every nibble >= 5, then shift the whole register left by one.
    always_comb begin
        bcd_adj = shift_reg[SR_W-1:IN_WIDTH];
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_adj[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
        end
        shift_next = {bcd_adj, shift_reg[IN_WIDTH-1:0]} << 1;
    end

    // IDLE -> SHIFT for IN_WIDTH cycles -> DONE for one cycle -> IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_cnt <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SHIFT;
                        shift_cnt <= '0;
                        shift_reg <= {{BCD_W{1'b0}}, value};
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_next;
                    if (shift_cnt == CNT_W'(IN_WIDTH - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign bcd  = shift_reg[SR_W-1:IN_WIDTH];

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment display driver with on-request binary-to-BCD capture.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int IN_WIDTH         = 14,
    parameter int REFRESH_DIV      = 100000,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int BLANK_LEADING    = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   num,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [6:0]            segments,
    output logic [IDX_W-1:0]      digit_idx
);

    localparam int              BCD_W     = 4 * NUM_DIGITS;
    localparam int              PRE_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam longint unsigned OVF_LIMIT = pow10(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ANODE_MASK = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            SEG_MASK   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

    logic                  conv_start;
    logic                  conv_busy;
    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    logic                  overflow_pend;
    logic [BCD_W-1:0]      disp_bcd;
    logic                  disp_ovf;
    logic [PRE_W-1:0]      prescaler;
    logic [IDX_W-1:0]      scan_idx;
    logic                  pre_tc;
    logic [NUM_DIGITS-1:0] onehot;
    logic [6:0]            seg_code;

    assign conv_start = load && !conv_busy;
    assign pre_tc     = (prescaler == PRE_W'(REFRESH_DIV - 1));

    bin2bcd_seq #(
        .IN_WIDTH   (IN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .value (num),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Latch the overflow verdict alongside the captured value.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_pend <= 1'b0;
        end else if (conv_start) begin
            overflow_pend <= (64'(num) >= OVF_LIMIT);
        end
    end

    // Display registers change only on commit, so a partial conversion is never shown.
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else if (conv_done) begin
            disp_bcd <= conv_bcd;
            disp_ovf <= overflow_pend;
        end
    end

    // Refresh prescaler and digit scan counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
            scan_idx  <= '0;
        end else if (pre_tc) begin
            prescaler <= '0;
            scan_idx  <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Select the scanned digit and resolve dash / leading-zero blank / decimal code.
    // run_zero walks from the top digit down, so it is true while every digit above and
    // including the current one is zero.
    always_comb begin
        logic run_zero;
        logic cur_blank;
        logic [3:0] cur_nib;
        run_zero  = 1'b1;
        cur_blank = 1'b0;
        cur_nib   = '0;
        onehot    = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            int unsigned i;
            i = NUM_DIGITS - 1 - k;
            run_zero = run_zero && (disp_bcd[4*i +: 4] == 4'd0);
            if (scan_idx == IDX_W'(i)) begin
                cur_nib   = disp_bcd[4*i +: 4];
                cur_blank = (BLANK_LEADING != 0) && (i != 0) && run_zero;
                onehot[i] = 1'b1;
            end
        end
        if (disp_ovf) begin
            seg_code = SEG_DASH;
        end else if (cur_blank) begin
            seg_code = SEG_BLANK;
        end else begin
            seg_code = seg7_decode(cur_nib);
        end
    end

    // Registered pin drive with polarity applied last.
    always_ff @(posedge clock) begin
        if (reset) begin
            anodes    <= NUM_DIGITS'(1) ^ ANODE_MASK;
            segments  <= SEG_CODE[0] ^ SEG_MASK;
            digit_idx <= '0;
        end else begin
            anodes    <= onehot ^ ANODE_MASK;
            segments  <= seg_code ^ SEG_MASK;
            digit_idx <= scan_idx;
        end
    end

    assign busy     = conv_busy;
    assign overflow = disp_ovf;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized self-checking bench: two display configurations against a value-level model.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] num_a = '0;
    logic        load_a = 1'b0;
    logic [19:0] num_b = '0;
    logic        load_b = 1'b0;

    logic        busy_a, ovf_a, busy_b, ovf_b;
    logic [3:0]  anodes_a;
    logic [5:0]  anodes_b;
    logic [6:0]  seg_a, seg_b;
    logic [1:0]  idx_a;
    logic [2:0]  idx_b;

    int checks = 0;
    int failures = 0;
    string phase = "init";

    always #5 clk = ~clk;

    seg7_scan_display #(
        .NUM_DIGITS(4), .IN_WIDTH(14), .REFRESH_DIV(4),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut_a (
        .clock(clk), .reset(reset), .num(num_a), .load(load_a),
        .busy(busy_a), .overflow(ovf_a), .anodes(anodes_a),
        .segments(seg_a), .digit_idx(idx_a)
    );

    seg7_scan_display #(
        .NUM_DIGITS(6), .IN_WIDTH(20), .REFRESH_DIV(3),
        .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0), .BLANK_LEADING(0)
    ) dut_b (
        .clock(clk), .reset(reset), .num(num_b), .load(load_b),
        .busy(busy_b), .overflow(ovf_b), .anodes(anodes_b),
        .segments(seg_b), .digit_idx(idx_b)
    );

    // Reference model: per-configuration parameters and value-level state.
    int cfg_nd [2]  = '{4, 6};
    int cfg_iw [2]  = '{14, 20};
    int cfg_rd [2]  = '{4, 3};
    int cfg_bl [2]  = '{1, 0};
    int cfg_sal[2]  = '{1, 0};
    int cfg_aal[2]  = '{1, 0};
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    longint unsigned m_disp [2];   // value in display registers
    longint unsigned m_view [2];   // value the pin registers currently reflect
    longint unsigned m_pend [2];
    int              m_wait [2];   // cycles until commit, 0 = idle
    int              m_cycles;     // edges since reset released

    function automatic longint unsigned p10(input int e);
        longint unsigned r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] exp_seg(input int k, input longint unsigned v, input int di);
        logic [6:0] code;
        longint unsigned p;
        p = p10(di);
        if (v >= p10(cfg_nd[k])) code = 7'h40;
        else if (cfg_bl[k] != 0 && di > 0 && v < p) code = 7'h00;
        else code = seg_tab[(v / p) % 10];
        if (cfg_sal[k] != 0) code = ~code;
        return 32'(code);
    endfunction

    function automatic logic [31:0] exp_anodes(input int k, input int di);
        logic [31:0] oh;
        logic [31:0] full;
        full = (32'd1 << cfg_nd[k]) - 32'd1;
        oh = 32'd1 << di;
        return (cfg_aal[k] != 0) ? (~oh & full) : oh;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s [%s] got=%0h expected=%0h t=%0t", tag, phase, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic lds [2];
        longint unsigned nums [2];
        lds[0] = load_a; lds[1] = load_b;
        nums[0] = 64'(num_a); nums[1] = 64'(num_b);
        if (reset) m_cycles = 0;
        else m_cycles++;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_wait[k] = 0; m_disp[k] = 0; m_view[k] = 0;
            end else begin
                m_view[k] = m_disp[k];
                if (m_wait[k] > 0) begin
                    m_wait[k]--;
                    if (m_wait[k] == 0) m_disp[k] = m_pend[k];
                end else if (lds[k]) begin
                    m_pend[k] = nums[k];
                    m_wait[k] = cfg_iw[k] + 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int di;
        for (int k = 0; k < 2; k++) begin
            di = (m_cycles == 0) ? 0 : ((m_cycles - 1) / cfg_rd[k]) % cfg_nd[k];
            if (k == 0) begin
                check_eq("a.busy", 32'(busy_a), 32'(m_wait[0] != 0));
                check_eq("a.overflow", 32'(ovf_a), 32'(m_disp[0] >= p10(4)));
                check_eq("a.digit_idx", 32'(idx_a), 32'(di));
                check_eq("a.anodes", 32'(anodes_a), exp_anodes(0, di));
                check_eq("a.segments", 32'(seg_a), exp_seg(0, m_view[0], di));
            end else begin
                check_eq("b.busy", 32'(busy_b), 32'(m_wait[1] != 0));
                check_eq("b.overflow", 32'(ovf_b), 32'(m_disp[1] >= p10(6)));
                check_eq("b.digit_idx", 32'(idx_b), 32'(di));
                check_eq("b.anodes", 32'(anodes_b), exp_anodes(1, di));
                check_eq("b.segments", 32'(seg_b), exp_seg(1, m_view[1], di));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic la, input logic [13:0] va, input logic lb, input logic [19:0] vb);
        num_a = va; load_a = la;
        num_b = vb; load_b = lb;
        step();
        load_a = 1'b0; load_b = 1'b0;
    endtask

    initial begin
        m_cycles = 0;
        for (int k = 0; k < 2; k++) begin
            m_disp[k] = 0; m_view[k] = 0; m_pend[k] = 0; m_wait[k] = 0;
        end

        phase = "reset";
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        run(20);

        phase = "load1234";
        pulse(1'b1, 14'd1234, 1'b1, 20'd7);
        run(40);

        phase = "load7";
        pulse(1'b1, 14'd7, 1'b0, 20'd0);
        run(30);

        phase = "overflow";
        pulse(1'b1, 14'd10000, 1'b1, 20'd999999);
        run(30);
        pulse(1'b1, 14'd9999, 1'b1, 20'd1000000);
        run(30);

        phase = "busy_ignore";
        pulse(1'b1, 14'd1234, 1'b0, 20'd0);
        run(3);
        pulse(1'b1, 14'd5678, 1'b1, 20'd123);
        run(20);
        pulse(1'b1, 14'd4321, 1'b0, 20'd0);
        run(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(30);

        phase = "random";
        for (int it = 0; it < 600; it++) begin
            logic la, lb;
            logic [13:0] va;
            logic [19:0] vb;
            la = ($urandom_range(0, 3) == 0);
            lb = ($urandom_range(0, 3) == 0);
            va = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 99)) : 14'($urandom_range(0, 16383));
            vb = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 999)) : 20'($urandom_range(0, 1048575));
            if ($urandom_range(0, 150) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end else begin
                pulse(la, va, lb, vb);
            end
        end
        run(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
